// File: rtl/dcache_controller.sv
// dcache_controller: direct-mapped, write-back, write-allocate L1 data cache.
// Hits are served combinationally from the internal arrays. A miss stalls the
// pipeline while a dirty victim is written back and the line is refilled.
module dcache_controller #(
  parameter int LINES     = 16,
  parameter int LINE_BITS = 256
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 cpu_req_i,
  input  logic                 cpu_we_i,
  input  logic [31:0]          cpu_addr_i,
  input  logic [31:0]          cpu_data_i,
  output logic [31:0]          cpu_data_o,
  output logic                 cpu_stall_o,
  output logic                 mem_req_o,
  output logic                 mem_we_o,
  output logic [31:0]          mem_addr_o,
  output logic [LINE_BITS-1:0] mem_data_o,
  input  logic [LINE_BITS-1:0] mem_data_i,
  input  logic                 mem_ack_i
);
  localparam int IDX   = $clog2(LINES);
  localparam int OFF   = $clog2(LINE_BITS / 8);
  localparam int TAG_W = 32 - OFF - IDX;
  localparam int WSEL  = OFF - 2;

  typedef enum logic [1:0] {IDLE, WRITEBACK, REFILL, UPDATE} state_t;

  state_t               state;
  logic [LINE_BITS-1:0] data_arr [LINES];
  logic [TAG_W-1:0]     tag_arr  [LINES];
  logic [LINES-1:0]     valid;
  logic [LINES-1:0]     dirty;
  logic [IDX-1:0]       miss_idx;
  logic [TAG_W-1:0]     miss_tag;
  logic [LINE_BITS-1:0] line_buf;

  logic [IDX-1:0]       cpu_idx;
  logic [TAG_W-1:0]     cpu_tag;
  logic [WSEL-1:0]      cpu_word;
  logic [LINE_BITS-1:0] cur_line;
  logic                 hit;
  logic                 store_hit;
  logic                 unused_addr_lsbs;

  assign cpu_idx          = cpu_addr_i[OFF +: IDX];
  assign cpu_tag          = cpu_addr_i[31 -: TAG_W];
  assign cpu_word         = cpu_addr_i[2 +: WSEL];
  assign unused_addr_lsbs = ^cpu_addr_i[1:0];
  assign cur_line         = data_arr[cpu_idx];

  // Hit detection and CPU-side responses, purely from the stored arrays
  always_comb begin
    hit         = cpu_req_i & valid[cpu_idx] & (tag_arr[cpu_idx] == cpu_tag);
    store_hit   = (state == IDLE) & hit & cpu_we_i;
    cpu_data_o  = hit ? cur_line[{cpu_word, 5'd0} +: 32] : 32'd0;
    cpu_stall_o = (state != IDLE) | (cpu_req_i & ~hit);
  end

  // Tag and data arrays: refill install wins, otherwise merge a store hit
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      if (state == UPDATE) begin
        data_arr[miss_idx] <= line_buf;
        tag_arr[miss_idx]  <= miss_tag;
      end else if (store_hit) begin
        data_arr[cpu_idx][{cpu_word, 5'd0} +: 32] <= cpu_data_i;
      end
    end
  end

  // Miss FSM with registered memory-side outputs and valid/dirty bookkeeping
  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state      <= IDLE;
      valid      <= '0;
      dirty      <= '0;
      miss_idx   <= '0;
      miss_tag   <= '0;
      line_buf   <= '0;
      mem_req_o  <= 1'b0;
      mem_we_o   <= 1'b0;
      mem_addr_o <= '0;
      mem_data_o <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cpu_req_i && !hit) begin
            miss_idx  <= cpu_idx;
            miss_tag  <= cpu_tag;
            mem_req_o <= 1'b1;
            if (valid[cpu_idx] && dirty[cpu_idx]) begin
              state      <= WRITEBACK;
              mem_we_o   <= 1'b1;
              mem_addr_o <= {tag_arr[cpu_idx], cpu_idx, {OFF{1'b0}}};
              mem_data_o <= data_arr[cpu_idx];
            end else begin
              state      <= REFILL;
              mem_we_o   <= 1'b0;
              mem_addr_o <= {cpu_tag, cpu_idx, {OFF{1'b0}}};
            end
          end else if (store_hit) begin
            dirty[cpu_idx] <= 1'b1;
          end
        end
        WRITEBACK: begin
          if (mem_ack_i) begin
            state      <= REFILL;
            mem_we_o   <= 1'b0;
            mem_addr_o <= {miss_tag, miss_idx, {OFF{1'b0}}};
            mem_data_o <= '0;
          end
        end
        REFILL: begin
          if (mem_ack_i) begin
            line_buf   <= mem_data_i;
            state      <= UPDATE;
            mem_req_o  <= 1'b0;
            mem_addr_o <= '0;
          end
        end
        UPDATE: begin
          valid[miss_idx] <= 1'b1;
          dirty[miss_idx] <= 1'b0;
          state           <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
